// File: rtl/uart_mmio_ctrl_pkg.sv
// Shared constants for the UART MMIO controller: register offsets, STATUS bit
// positions, TX state encoding and the clocks-per-bit helper.
package uart_ctrl_pkg;

    // Register offsets from BASE_ADDR
    localparam logic [31:0] OFF_TXDATA = 32'h0;
    localparam logic [31:0] OFF_RXDATA = 32'h4;
    localparam logic [31:0] OFF_STATUS = 32'h8;

    // STATUS bit positions
    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_RX_VALID = 2;
    localparam int unsigned ST_RX_OVR   = 3;
    localparam int unsigned ST_PAR_ERR  = 4;
    localparam int unsigned ST_TX_OVF   = 5;
    localparam int unsigned ST_TX_IE    = 6;
    localparam int unsigned StatusW     = 7;

    // TX state encoding
    typedef logic [1:0] tx_state_t;
    localparam tx_state_t TX_IDLE = 2'd0;
    localparam tx_state_t TX_LOAD = 2'd1;
    localparam tx_state_t TX_WAIT = 2'd2;

    function automatic int unsigned calc_cpb(int unsigned clk_freq, int unsigned baudrate);
        return clk_freq / baudrate;
    endfunction

    // Clocks per bit at the default clock and line rate
    localparam int unsigned CPB = calc_cpb(50000000, 9600);

endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// CPU data-bus view of the UART controller: single-cycle write/read strobes.
interface uart_mmio_ctrl_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output we, output re, input rdata);
    modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/uart_mmio_ctrl_tx_fifo.sv
// Circular-buffer TX FIFO. Pointers carry one extra wrap bit to tell full from
// empty; a push into a full FIFO is taken when a pop frees a slot that cycle.
module uart_tx_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] head
);
    localparam int unsigned AddrW = $clog2(Depth);

    logic [AddrW:0]   wr_ptr_q;
    logic [AddrW:0]   rd_ptr_q;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q[AddrW-1:0]];

    // Pointer update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata;
    end
endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TX FIFO with frame-spaced Transmit pulses,
// RX byte capture with acknowledge, and TXDATA/RXDATA/STATUS registers.
module uart_mmio_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned Nbit       = 8,
    parameter int unsigned baudrate   = 9600,
    parameter int unsigned clk_freq   = 50000000,
    parameter int unsigned FRAME_BITS = 11,
    parameter int unsigned TX_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h10010028
) (
    input  logic            clk,
    input  logic            reset,
    uart_mmio_ctrl_if.slave bus,
    output logic            irq,
    output logic            Transmit,
    output logic [Nbit-1:0] DataTx,
    output logic            clr_rx_flag,
    input  logic [Nbit-1:0] DataRx,
    input  logic            Rx_flag,
    input  logic            Parity_error
);
    localparam int unsigned Cpb         = calc_cpb(clk_freq, baudrate);
    localparam int unsigned FrameCycles = FRAME_BITS * Cpb;
    localparam int unsigned CntW        = $clog2(FrameCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FrameCycles - 1);

    logic sel_tx, sel_rx, sel_st;
    logic wr_tx, wr_st, rd_rx;
    logic fifo_full, fifo_empty, tx_pop;
    logic [Nbit-1:0] fifo_head;

    tx_state_t       tx_state_q;
    logic [CntW-1:0] tx_cnt_q;
    logic [Nbit-1:0] data_tx_q;

    logic            rx_armed_q, rx_capture, clr_rx_flag_q;
    logic            rx_valid_q, rx_ovr_q, par_err_q, tx_ovf_q, tx_ie_q;
    logic [Nbit-1:0] rx_byte_q;
    logic            tx_empty;
    logic [StatusW-1:0] status;
    logic            unused_wdata;

    assign sel_tx = (bus.addr == BASE_ADDR + OFF_TXDATA);
    assign sel_rx = (bus.addr == BASE_ADDR + OFF_RXDATA);
    assign sel_st = (bus.addr == BASE_ADDR + OFF_STATUS);
    assign wr_tx  = bus.we && sel_tx;
    assign wr_st  = bus.we && sel_st;
    assign rd_rx  = bus.re && sel_rx;
    assign unused_wdata = ^bus.wdata[31:Nbit];

    uart_tx_fifo #(
        .Depth (TX_DEPTH),
        .Width (Nbit)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_tx),
        .pop   (tx_pop),
        .wdata (bus.wdata[Nbit-1:0]),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign tx_pop   = (tx_state_q == TX_IDLE) && !fifo_empty;
    assign tx_empty = fifo_empty && (tx_state_q == TX_IDLE);
    assign Transmit = (tx_state_q == TX_LOAD);
    assign DataTx   = data_tx_q;

    // TX sequencer; tx_cnt_q counts frame cycles starting at the Transmit cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            data_tx_q  <= '0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        tx_state_q <= TX_LOAD;
                        data_tx_q  <= fifo_head;
                        tx_cnt_q   <= '0;
                    end
                end
                TX_LOAD: begin
                    tx_state_q <= TX_WAIT;
                    tx_cnt_q   <= tx_cnt_q + 1'b1;
                end
                TX_WAIT: begin
                    if (tx_cnt_q == CntLast) tx_state_q <= TX_IDLE;
                    else                     tx_cnt_q   <= tx_cnt_q + 1'b1;
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // Re-arm only after Rx_flag has been seen low, so one byte is taken once
    assign rx_capture = Rx_flag && rx_armed_q && !clr_rx_flag_q;

    // RX capture, acknowledge and valid flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_armed_q    <= 1'b1;
            clr_rx_flag_q <= 1'b0;
            rx_byte_q     <= '0;
            rx_valid_q    <= 1'b0;
        end else begin
            clr_rx_flag_q <= rx_capture;
            if (rx_capture)    rx_armed_q <= 1'b0;
            else if (!Rx_flag) rx_armed_q <= 1'b1;
            if (rx_capture) begin
                rx_byte_q  <= DataRx;
                rx_valid_q <= 1'b1;
            end else if (rd_rx) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign clr_rx_flag = clr_rx_flag_q;

    // Sticky error bits (set wins over a same-cycle W1C) and interrupt enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_ovr_q  <= 1'b0;
            par_err_q <= 1'b0;
            tx_ovf_q  <= 1'b0;
            tx_ie_q   <= 1'b0;
        end else begin
            rx_ovr_q  <= (rx_capture && rx_valid_q && !rd_rx) ||
                         (rx_ovr_q && !(wr_st && bus.wdata[ST_RX_OVR]));
            par_err_q <= (rx_capture && Parity_error) ||
                         (par_err_q && !(wr_st && bus.wdata[ST_PAR_ERR]));
            tx_ovf_q  <= (wr_tx && fifo_full && !tx_pop) ||
                         (tx_ovf_q && !(wr_st && bus.wdata[ST_TX_OVF]));
            if (wr_st) tx_ie_q <= bus.wdata[ST_TX_IE];
        end
    end

    // STATUS assembly and combinational read mux
    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = fifo_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_VALID] = rx_valid_q;
        status[ST_RX_OVR]   = rx_ovr_q;
        status[ST_PAR_ERR]  = par_err_q;
        status[ST_TX_OVF]   = tx_ovf_q;
        status[ST_TX_IE]    = tx_ie_q;
        bus.rdata = '0;
        if (sel_rx)      bus.rdata[Nbit-1:0]    = rx_byte_q;
        else if (sel_st) bus.rdata[StatusW-1:0] = status;
    end

    assign irq = rx_valid_q || (tx_empty && tx_ie_q);
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Bench for uart_mmio_ctrl: directed bus/RX stimulus, an event-level model of
// the register map and TX timing, and literal checks on key values.
module tb_uart_mmio_ctrl;
    localparam int unsigned FB    = 11;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CLKF  = 1000;
    localparam int unsigned BAUD  = 250;
    localparam int FC     = FB * (CLKF / BAUD);  // 44 cycles per frame
    localparam int PERIOD = FC + 1;
    localparam logic [31:0] BASE  = 32'h10010028;
    localparam logic [31:0] A_TX  = BASE;
    localparam logic [31:0] A_RX  = BASE + 32'h4;
    localparam logic [31:0] A_ST  = BASE + 32'h8;
    localparam logic [31:0] A_BAD = BASE + 32'hC;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       irq, Transmit, clr_rx_flag;
    logic [7:0] DataTx;
    logic [7:0] DataRx = 8'h00;
    logic       Rx_flag = 1'b0;
    logic       Parity_error = 1'b0;

    uart_mmio_ctrl_if bus ();

    uart_mmio_ctrl #(
        .Nbit       (8),
        .baudrate   (BAUD),
        .clk_freq   (CLKF),
        .FRAME_BITS (FB),
        .TX_DEPTH   (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .irq          (irq),
        .Transmit     (Transmit),
        .DataTx       (DataTx),
        .clr_rx_flag  (clr_rx_flag),
        .DataRx       (DataRx),
        .Rx_flag      (Rx_flag),
        .Parity_error (Parity_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    // Model state
    typedef struct {
        logic [7:0] b;
        int         c;
    } tx_ent_t;
    tx_ent_t    exp_q[$];
    int         pulse_log[$];
    int         last_pulse;
    logic [7:0] last_byte;
    logic       m_valid, m_ovr, m_par, m_ovf, m_ie, m_armed;
    logic [7:0] m_byte;
    int         clr_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_pulse = -100000;
        last_byte  = 8'h00;
        m_valid = 0; m_ovr = 0; m_par = 0; m_ovf = 0; m_ie = 0; m_armed = 1;
        m_byte  = 8'h00;
        clr_exp = -1;
    endtask

    function automatic logic tx_empty_m();
        return (exp_q.size() == 0) && (cyc >= last_pulse + FC);
    endfunction

    function automatic logic [31:0] read_model(input logic [31:0] a);
        if (a == A_RX) return {24'h0, m_byte};
        if (a == A_ST)
            return {25'h0, m_ie, m_ovf, m_par, m_ovr, m_valid, tx_empty_m(),
                    logic'(exp_q.size() == DEPTH)};
        return 32'h0;
    endfunction

    // Per-cycle output check against the model
    always @(negedge clk) begin : compare
        int nxt;
        if (checking) begin
            nxt = -1;
            if (exp_q.size() > 0) begin
                nxt = exp_q[0].c + 2;
                if (last_pulse + PERIOD > nxt) nxt = last_pulse + PERIOD;
            end
            chk("transmit", Transmit, (cyc == nxt));
            if (Transmit && exp_q.size() > 0) begin
                chk("data_tx", DataTx, exp_q[0].b);
                last_pulse = cyc;
                last_byte  = exp_q[0].b;
                pulse_log.push_back(cyc);
                void'(exp_q.pop_front());
            end else if (cyc < last_pulse + FC) begin
                chk("data_tx_hold", DataTx, last_byte);
            end
            chk("clr_rx_flag", clr_rx_flag, (cyc == clr_exp));
            chk("irq", irq, m_valid || (tx_empty_m() && m_ie));
        end
    end

    // One bus/RX cycle starting just after a rising edge
    task automatic bus_cycle(input logic w, input logic r, input logic [31:0] a,
                             input logic [31:0] d, input logic rxon, input logic [7:0] rxb,
                             input logic rxp, input logic accept, output logic [31:0] rd);
        int c;
        logic rd_rx, cap;
        c = cyc;
        bus.we = w; bus.re = r; bus.addr = a; bus.wdata = d;
        Rx_flag = rxon; DataRx = rxb; Parity_error = rxp;
        @(negedge clk); #1;
        rd = bus.rdata;
        if (r && a != A_TX) chk("rdata", rd, read_model(a));
        @(posedge clk);
        if (w && a == A_TX) begin
            if (accept) exp_q.push_back('{b: d[7:0], c: c});
            else        m_ovf = 1'b1;
        end
        if (w && a == A_ST) begin
            if (d[3]) m_ovr = 1'b0;
            if (d[4]) m_par = 1'b0;
            if (d[5]) m_ovf = 1'b0;
            m_ie = d[6];
        end
        rd_rx = r && (a == A_RX);
        cap = rxon && m_armed;
        if (cap) begin
            if (m_valid && !rd_rx) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_byte  = rxb;
            m_par   = m_par | rxp;
            m_armed = 1'b0;
            clr_exp = c + 1;
        end else if (rd_rx) begin
            m_valid = 1'b0;
        end
        if (!rxon) m_armed = 1'b1;
        #1;
    endtask

    logic [31:0] rd;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(0, 0, A_BAD, 0, 0, 8'h00, 0, 1, rd);
    endtask
    task automatic idle_until(input int t);
        while (cyc < t) bus_cycle(0, 0, A_BAD, 0, 0, 8'h00, 0, 1, rd);
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic accept);
        bus_cycle(1, 0, a, d, 0, 8'h00, 0, accept, rd);
    endtask
    task automatic rdreg(input logic [31:0] a, input string name, input logic [31:0] lit);
        bus_cycle(0, 1, a, 0, 0, 8'h00, 0, 1, rd);
        chk(name, rd, lit);
    endtask
    task automatic rx(input logic [7:0] b, input logic p);
        bus_cycle(0, 0, A_BAD, 0, 1, b, p, 1, rd);
    endtask

    initial begin : main
        int w, n0;
        model_reset();
        bus.we = 0; bus.re = 0; bus.addr = A_BAD; bus.wdata = 0;

        // Reset held with bus activity and Rx_flag high
        Rx_flag = 1; DataRx = 8'hFF; Parity_error = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.we = (i % 2 == 0); bus.re = (i % 2 == 1);
            bus.addr = (i % 2 == 0) ? A_TX : A_ST; bus.wdata = 32'hAB;
            @(negedge clk); #1;
            chk("rst_transmit", Transmit, 0);
            chk("rst_clr", clr_rx_flag, 0);
            chk("rst_irq", irq, 0);
            chk("rst_datatx", DataTx, 0);
            if (i % 2 == 1) chk("rst_status", bus.rdata, 32'h2);
        end
        @(posedge clk); #1;
        bus.we = 0; bus.re = 0; Rx_flag = 0; Parity_error = 0;
        reset = 1; checking = 1;
        idle(3);
        rdreg(A_ST, "status_after_reset", 32'h02);

        // Single byte
        w = cyc; n0 = pulse_log.size();
        wr(A_TX, 32'h55, 1);
        idle(FC + 4);
        chk("single_pulse_time", pulse_log[n0] - w, 2);
        rdreg(A_ST, "status_tx_done", 32'h02);

        // Burst of five plus one dropped while full
        w = cyc; n0 = pulse_log.size();
        for (int i = 1; i <= 5; i++) wr(A_TX, i, 1);
        wr(A_TX, 32'h06, 0);
        rdreg(A_ST, "status_full_ovf", 32'h21);
        wr(A_ST, 32'h20, 1);
        rdreg(A_ST, "status_ovf_cleared", 32'h01);
        idle(4 * PERIOD + FC);
        chk("burst_first_time", pulse_log[n0] - w, 2);
        for (int i = 1; i < 5; i++)
            chk("burst_spacing", pulse_log[n0 + i] - pulse_log[n0 + i - 1], PERIOD);

        // Push into a full FIFO in the cycle the head is popped
        w = cyc;
        for (int i = 0; i < 5; i++) wr(A_TX, 32'hA0 + i, 1);
        idle_until(w + FC + 2);
        wr(A_TX, 32'hA5, 1);
        rdreg(A_ST, "status_full_after_swap", 32'h01);
        idle(5 * PERIOD);

        // RX capture and read
        rx(8'hA3, 0);
        idle(1);
        chk("irq_rx", irq, 1);
        rdreg(A_ST, "status_rx_valid", 32'h06);
        rdreg(A_RX, "rxdata_a3", 32'hA3);
        rdreg(A_ST, "status_rx_read", 32'h02);

        // Overrun with parity error, then selective W1C
        rx(8'h3C, 0);
        idle(1);
        rx(8'hC5, 1);
        idle(1);
        rdreg(A_ST, "status_ovr_par", 32'h1E);
        wr(A_ST, 32'h18, 1);
        rdreg(A_ST, "status_w1c", 32'h06);
        rdreg(A_RX, "rxdata_c5", 32'hC5);

        // Flag held high for two cycles: one capture only
        rx(8'h77, 0);
        rx(8'h77, 0);
        idle(1);
        rdreg(A_ST, "status_edge_guard", 32'h06);
        rdreg(A_RX, "rxdata_77", 32'h77);

        // Capture and RXDATA read in the same cycle
        rx(8'h11, 0);
        idle(1);
        bus_cycle(0, 1, A_RX, 0, 1, 8'h22, 0, 1, rd);
        chk("simul_old_byte", rd, 32'h11);
        idle(1);
        rdreg(A_ST, "status_simul", 32'h06);
        rdreg(A_RX, "rxdata_22", 32'h22);

        // TX interrupt enable and unmapped access
        wr(A_ST, 32'h40, 1);
        idle(1);
        chk("irq_tx_ie", irq, 1);
        wr(A_BAD, 32'hFF, 1);
        rdreg(A_BAD, "unmapped_read", 32'h0);
        rdreg(A_ST, "status_ie", 32'h42);
        wr(A_TX, 32'h3E, 1);
        idle(PERIOD + 2);
        wr(A_ST, 32'h00, 1);

        // Reset in the middle of a frame
        wr(A_TX, 32'h99, 1);
        idle(10);
        reset = 0; checking = 0;
        model_reset();
        @(negedge clk); #1;
        chk("midrst_transmit", Transmit, 0);
        bus.addr = A_ST;
        #1;
        chk("midrst_status", bus.rdata, 32'h02);
        @(posedge clk); #1;
        reset = 1; checking = 1;
        idle(FC + 10);
        rdreg(A_ST, "status_after_midrst", 32'h02);

        chk("tx_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
